// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and bit-period helper,
// common to the transmit path and the future instruction-load receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Integer-truncated clock cycles per serial bit.
    function automatic int unsigned clks_per_bit(input int unsigned freq,
                                                 input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, flags the terminal count and
// the cycle just before it so the caller can register end-of-bit strobes.
module baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic near_tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick      = (count == CNT_W'(CLKS_PER_BIT - 1));
    assign near_tick = (count == CNT_W'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (1 or 2 stop bits) draining the byte-dump stream;
// Tx_busy gives the producer flow control, all outputs come from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       Ready_Byte,
    output logic       Tx_busy,
    output logic       tx,
    output logic       tx_done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t         state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                stop_q, stop_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tick, near_tick, baud_clear;

    // Bit timer is held at zero while idle so the start bit gets a full period.
    assign baud_clear = (state_q == IDLE);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (baud_clear),
        .tick     (tick),
        .near_tick(near_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (Ready_Byte && !busy_q) begin
                    state_d = START;
                    shift_d = din;
                    idx_d   = '0;
                    stop_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                // Registered one cycle early so the pulse lands on the final stop cycle.
                if (stop_q == STOP_LAST && near_tick) done_d = 1'b1;
                if (tick) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign Tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast instance (4 clk/bit, 1 stop) for framing
// and handshake cases, and a full-rate instance (434 clk/bit, 2 stops).
`timescale 1ns/1ps
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_f, rdy_f, busy_f, tx_f, done_f;
    logic [7:0] din_f;
    logic       rst_s, rdy_s, busy_s, tx_s, done_s;
    logic [7:0] din_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ(16), .BAUD(4), .CLKS_PER_BIT(4), .STOP_BITS(1)
    ) u_fast (
        .clk(clk), .rst(rst_f), .din(din_f), .Ready_Byte(rdy_f),
        .Tx_busy(busy_f), .tx(tx_f), .tx_done(done_f)
    );

    uart_tx #(
        .CLK_FREQ(50_000_000), .BAUD(115200), .CLKS_PER_BIT(434), .STOP_BITS(2)
    ) u_slow (
        .clk(clk), .rst(rst_s), .din(din_s), .Ready_Byte(rdy_s),
        .Tx_busy(busy_s), .tx(tx_s), .tx_done(done_s)
    );

    // Expected line level i cycles after acceptance: start, 8 data LSB first, then high.
    function automatic logic frame_bit(input logic [7:0] b, input int i, input int cpb);
        int k;
        k = i / cpb;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst_f = 1'b1; rdy_f = 1'b0; din_f = 8'h00;
        rst_s = 1'b1; rdy_s = 1'b0; din_s = 8'h00;
        #2;
        rst_f = 1'b0; rst_s = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (tx_f !== 1'b1)   begin errors++; $display("FAIL reset_tx got=%b exp=1", tx_f); end
        if (busy_f !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_f); end
        if (done_f !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_f); end
        if (tx_s !== 1'b1)   begin errors++; $display("FAIL reset_tx_slow got=%b exp=1", tx_s); end
        rst_f = 1'b1; rst_s = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (tx_f !== 1'b1 || busy_f !== 1'b0 || done_f !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset cyc=%0d got tx/busy/done=%b%b%b exp=100",
                         i, tx_f, busy_f, done_f);
            end
        end
    endtask

    task automatic test_single();
        din_f = 8'hA5; rdy_f = 1'b1;
        @(negedge clk);
        rdy_f = 1'b0;
        for (int i = 0; i < 42; i++) begin
            checks += 3;
            if (tx_f !== frame_bit(8'hA5, i, 4)) begin
                errors++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", i, tx_f, frame_bit(8'hA5, i, 4));
            end
            if (busy_f !== (i < 40)) begin
                errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", i, busy_f, (i < 40));
            end
            if (done_f !== (i == 39)) begin
                errors++; $display("FAIL single_done cyc=%0d got=%b exp=%b", i, done_f, (i == 39));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_busy_ignore();
        din_f = 8'h3C; rdy_f = 1'b1;
        @(negedge clk);
        rdy_f = 1'b0;
        for (int i = 0; i < 50; i++) begin
            checks += 3;
            if (tx_f !== frame_bit(8'h3C, i, 4)) begin
                errors++; $display("FAIL busy_ignore_tx cyc=%0d got=%b exp=%b", i, tx_f, frame_bit(8'h3C, i, 4));
            end
            if (busy_f !== (i < 40)) begin
                errors++; $display("FAIL busy_ignore_busy cyc=%0d got=%b exp=%b", i, busy_f, (i < 40));
            end
            if (done_f !== (i == 39)) begin
                errors++; $display("FAIL busy_ignore_done cyc=%0d got=%b exp=%b", i, done_f, (i == 39));
            end
            if (i == 10) begin din_f = 8'hFF; rdy_f = 1'b1; end
            if (i == 11) rdy_f = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_tx, exp_busy, exp_done;
        int   j;
        din_f = 8'h01; rdy_f = 1'b1;
        @(negedge clk);
        din_f = 8'h80;
        for (int i = 0; i < 86; i++) begin
            if (i < 41) begin
                exp_tx = frame_bit(8'h01, i, 4); exp_busy = (i < 40); exp_done = (i == 39);
            end else begin
                j = i - 41;
                exp_tx = frame_bit(8'h80, j, 4); exp_busy = (j < 40); exp_done = (j == 39);
            end
            checks += 3;
            if (tx_f !== exp_tx) begin
                errors++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", i, tx_f, exp_tx);
            end
            if (busy_f !== exp_busy) begin
                errors++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", i, busy_f, exp_busy);
            end
            if (done_f !== exp_done) begin
                errors++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", i, done_f, exp_done);
            end
            if (i == 41) rdy_f = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        din_f = 8'h55; rdy_f = 1'b1;
        @(negedge clk);
        rdy_f = 1'b0;
        repeat (17) @(negedge clk);
        checks++;
        if (tx_f !== 1'b0) begin errors++; $display("FAIL mid_bit3_tx got=%b exp=0", tx_f); end
        #2 rst_f = 1'b0;
        #1;
        checks += 3;
        if (tx_f !== 1'b1)   begin errors++; $display("FAIL mid_reset_tx got=%b exp=1", tx_f); end
        if (busy_f !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy_f); end
        if (done_f !== 1'b0) begin errors++; $display("FAIL mid_reset_done got=%b exp=0", done_f); end
        repeat (2) @(negedge clk);
        rst_f = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_f !== 1'b1 || busy_f !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got tx/busy=%b%b exp=10", tx_f, busy_f);
        end
        din_f = 8'hC3; rdy_f = 1'b1;
        @(negedge clk);
        rdy_f = 1'b0;
        for (int i = 0; i < 42; i++) begin
            checks += 2;
            if (tx_f !== frame_bit(8'hC3, i, 4)) begin
                errors++; $display("FAIL post_reset_tx cyc=%0d got=%b exp=%b", i, tx_f, frame_bit(8'hC3, i, 4));
            end
            if (busy_f !== (i < 40)) begin
                errors++; $display("FAIL post_reset_busy cyc=%0d got=%b exp=%b", i, busy_f, (i < 40));
            end
            @(negedge clk);
        end
    endtask

    // Full-rate frame measured by cycle counts; bounded so a stuck Tx_busy still ends.
    task automatic test_two_stop_bits(input logic [7:0] b, input int exp_low, input int exp_high);
        int busy_cnt = 0, low_cnt = 0, high_cnt = 0, done_cnt = 0, done_at = -1;
        din_s = b; rdy_s = 1'b1;
        @(negedge clk);
        rdy_s = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (!busy_s) break;
            busy_cnt++;
            if (tx_s == 1'b0) low_cnt++;
            else high_cnt++;
            if (done_s) begin done_cnt++; done_at = i; end
            @(negedge clk);
        end
        checks += 6;
        if (busy_cnt != 4774) begin errors++; $display("FAIL slow_busy_len data=%h got=%0d exp=4774", b, busy_cnt); end
        if (low_cnt != exp_low) begin errors++; $display("FAIL slow_low_len data=%h got=%0d exp=%0d", b, low_cnt, exp_low); end
        if (high_cnt != exp_high) begin errors++; $display("FAIL slow_high_len data=%h got=%0d exp=%0d", b, high_cnt, exp_high); end
        if (done_cnt != 1) begin errors++; $display("FAIL slow_done_count data=%h got=%0d exp=1", b, done_cnt); end
        if (done_at != 4773) begin errors++; $display("FAIL slow_done_cycle data=%h got=%0d exp=4773", b, done_at); end
        if (tx_s !== 1'b1) begin errors++; $display("FAIL slow_idle_tx data=%h got=%b exp=1", b, tx_s); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        // 8'h00: start+data low (9*434), stop high (2*434)
        test_two_stop_bits(8'h00, 3906, 868);
        // 8'hFF: only the start bit is low, giving its width directly
        test_two_stop_bits(8'hFF, 434, 4340);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
